// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants and helpers for the eight-digit multiplexed seven-segment scanner.
package display_scan_ctrl_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam logic [7:0]  DIGIT_OFF  = 8'hFF;
    localparam logic [7:0]  SEG_BLANK  = 8'hFF;

    typedef logic [3:0] nibble_t;
    typedef logic [2:0] digit_idx_t;

    function automatic nibble_t pick_nibble(input logic [31:0] v, input digit_idx_t idx);
        return v[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Host-side bundle for the display scanner: value/load/blank controls and the scan outputs.
interface display_scan_ctrl_if;

    logic [31:0] value;
    logic        load;
    logic        blank_lz;
    logic        pending;
    logic [7:0]  digitselect;
    logic [7:0]  segments;

    modport master (
        output value, load, blank_lz,
        input  pending, digitselect, segments
    );

    modport slave (
        input  value, load, blank_lz,
        output pending, digitselect, segments
    );

endinterface

// File: rtl/display_scan_ctrl_hexto7seg.sv
// Hex nibble to active-low seven-segment pattern {a,b,c,d,e,f,g,dp}; dp stays off.
module hexto7seg
    import display_scan_ctrl_pkg::*;
(
    input  nibble_t    nibble_i,
    output logic [7:0] segments_o
);

    logic [7:0] pat_hi;

    always_comb begin
        pat_hi = '0;
        case (nibble_i)
            4'h0: pat_hi = 8'hFC;
            4'h1: pat_hi = 8'h60;
            4'h2: pat_hi = 8'hDA;
            4'h3: pat_hi = 8'hF2;
            4'h4: pat_hi = 8'h66;
            4'h5: pat_hi = 8'hB6;
            4'h6: pat_hi = 8'hBE;
            4'h7: pat_hi = 8'hE0;
            4'h8: pat_hi = 8'hFE;
            4'h9: pat_hi = 8'hF6;
            4'hA: pat_hi = 8'hEE;
            4'hB: pat_hi = 8'h3E;
            4'hC: pat_hi = 8'h9C;
            4'hD: pat_hi = 8'h7A;
            4'hE: pat_hi = 8'h9E;
            4'hF: pat_hi = 8'h8E;
            default: pat_hi = '0;
        endcase
    end

    assign segments_o = ~pat_hi;

endmodule

// File: rtl/display_scan_ctrl.sv
// Eight-digit multiplexed display scanner with frame-synchronised (tear-free) value update
// and optional leading-zero blanking.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int unsigned REFRESH_BITS = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] value,
    input  logic        load,
    input  logic        blank_lz,
    output logic        pending,
    output logic [7:0]  digitselect,
    output logic [7:0]  segments
);

    logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
    digit_idx_t              dig_q, dig_d;
    logic [31:0]             shown_q, shown_d;
    logic [31:0]             shadow_q, shadow_d;
    logic                    pending_q, pending_d;

    logic                    cnt_max;
    logic                    frame_end;
    logic [NUM_DIGITS-1:0]   zero_above;
    logic                    blank;
    nibble_t                 cur_nibble;
    logic [7:0]              dec_seg;

    assign cnt_max   = &cnt_q;
    assign frame_end = cnt_max && (dig_q == digit_idx_t'(NUM_DIGITS - 1));

    // shown only moves on frame_end; a load landing on frame_end bypasses the shadow.
    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        dig_d     = cnt_max ? dig_q + 3'd1 : dig_q;
        shown_d   = shown_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (frame_end) begin
            if (load) begin
                shown_d = value;
            end else if (pending_q) begin
                shown_d = shadow_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            shadow_d  = value;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            dig_q     <= '0;
            shown_q   <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dig_q     <= dig_d;
            shown_q   <= shown_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
        end
    end

    // zero_above[i]: nibbles i..7 of shown are all zero.
    always_comb begin
        zero_above = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            zero_above[i] = ((shown_q >> (4 * i)) == 32'd0);
        end
    end

    assign blank      = blank_lz && (dig_q != 3'd0) && zero_above[dig_q];
    assign cur_nibble = pick_nibble(shown_q, dig_q);

    hexto7seg u_dec (
        .nibble_i   (cur_nibble),
        .segments_o (dec_seg)
    );

    assign pending     = pending_q;
    assign digitselect = blank ? DIGIT_OFF : ~(8'b1 << dig_q);
    assign segments    = blank ? SEG_BLANK : dec_seg;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed scoreboard bench for display_scan_ctrl with a 4-clock digit dwell (32-clock frame).
module tb_display_scan_ctrl;

    logic clk;
    logic reset;
    int   cyc;
    int   fpos;
    int   n_chk;
    int   n_fail;

    display_scan_ctrl_if bus ();

    display_scan_ctrl #(.REFRESH_BITS(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .value       (bus.value),
        .load        (bus.load),
        .blank_lz    (bus.blank_lz),
        .pending     (bus.pending),
        .digitselect (bus.digitselect),
        .segments    (bus.segments)
    );

    typedef struct {
        int          stamp;
        string       name;
        logic [7:0]  ds;
        logic [7:0]  seg;
        logic        pend;
    } exp_t;

    exp_t sb[$];

    // Active-low patterns, hand-inverted from the active-high hex table.
    localparam logic [7:0] SEGTAB [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };
    localparam logic [7:0] DSTAB [8] = '{
        8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F
    };

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic push_d(input string nm, input logic [31:0] shw, input int d, input logic pend);
        exp_t   e;
        logic [31:0] sh;
        logic [3:0]  nib;
        sh  = shw >> (4 * d);
        nib = sh[3:0];
        e.stamp = cyc;
        e.name  = nm;
        e.pend  = pend;
        if (bus.blank_lz && d != 0 && sh == 32'd0) begin
            e.ds  = 8'hFF;
            e.seg = 8'hFF;
        end else begin
            e.ds  = DSTAB[d];
            e.seg = SEGTAB[nib];
        end
        sb.push_back(e);
    endtask

    task automatic push(input string nm, input logic [31:0] shw, input logic pend);
        push_d(nm, shw, (fpos / 4) % 8, pend);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        fpos++;
    endtask

    task automatic run(input string nm, input int n, input logic [31:0] shw, input logic pend);
        for (int k = 0; k < n; k++) begin
            push(nm, shw, pend);
            tick();
        end
    endtask

    task automatic load_cyc(input string nm, input logic [31:0] v, input logic [31:0] shw,
                            input logic pend);
        bus.value = v;
        bus.load  = 1'b1;
        push(nm, shw, pend);
        tick();
        bus.load  = 1'b0;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].stamp <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            n_chk++;
            if (e.stamp != cyc || bus.digitselect !== e.ds || bus.segments !== e.seg
                || bus.pending !== e.pend) begin
                n_fail++;
                $display("FAIL %s cyc=%0d: got ds=%h seg=%h pend=%b, required ds=%h seg=%h pend=%b (stamp %0d)",
                         e.name, cyc, bus.digitselect, bus.segments, bus.pending,
                         e.ds, e.seg, e.pend, e.stamp);
            end
        end
    end

    initial begin
        n_chk        = 0;
        n_fail       = 0;
        fpos         = 0;
        reset        = 1'b1;
        bus.value    = '0;
        bus.load     = 1'b0;
        bus.blank_lz = 1'b0;

        @(posedge clk); #1;
        push_d("rst_hold", 32'h0, 0, 1'b0);
        @(posedge clk); #1;
        push_d("rst_hold2", 32'h0, 0, 1'b0);
        reset = 1'b0;
        fpos  = 0;

        // Free run: every digit shows 0.
        run("free", 32, 32'h0, 1'b0);

        // Load at digit 2, pending until frame end, then new frame.
        run("pre_ld", 8, 32'h0, 1'b0);
        load_cyc("ld_1234", 32'h1234_ABCD, 32'h0, 1'b0);
        run("pend_1234", 23, 32'h0, 1'b1);
        run("frm_1234", 32, 32'h1234_ABCD, 1'b0);

        // Two loads in one frame: last one wins.
        run("f3_pre", 4, 32'h1234_ABCD, 1'b0);
        load_cyc("ld_1111", 32'h1111_1111, 32'h1234_ABCD, 1'b0);
        run("pend_1111", 9, 32'h1234_ABCD, 1'b1);
        load_cyc("ld_2222", 32'h2222_2222, 32'h1234_ABCD, 1'b1);
        run("pend_2222", 17, 32'h1234_ABCD, 1'b1);
        run("frm_2222", 32, 32'h2222_2222, 1'b0);

        // Load exactly on frame_end: immediate, pending never rises.
        run("f5_pre", 31, 32'h2222_2222, 1'b0);
        load_cyc("ld_fe_f0", 32'h0000_00F0, 32'h2222_2222, 1'b0);
        run("frm_f0", 31, 32'h0000_00F0, 1'b0);

        // Frame-end load of 0x305, then leading-zero blanking.
        load_cyc("ld_fe_305", 32'h0000_0305, 32'h0000_00F0, 1'b0);
        bus.blank_lz = 1'b1;
        run("blank_305", 32, 32'h0000_0305, 1'b0);

        // Reset while pending at digit 5: shadow discarded, load during reset ignored.
        run("f8_pre", 2, 32'h0000_0305, 1'b0);
        load_cyc("ld_dead", 32'hDEAD_BEEF, 32'h0000_0305, 1'b0);
        run("pend_dead", 17, 32'h0000_0305, 1'b1);
        reset     = 1'b1;
        bus.value = 32'h1234_5678;
        bus.load  = 1'b1;
        #1;
        push_d("rst_async", 32'h0, 0, 1'b0);
        @(posedge clk); #1;
        push_d("rst_ld", 32'h0, 0, 1'b0);
        @(posedge clk); #1;
        push_d("rst_ld2", 32'h0, 0, 1'b0);
        reset        = 1'b0;
        bus.load     = 1'b0;
        bus.blank_lz = 1'b0;
        fpos         = 0;
        run("post_rst", 64, 32'h0, 1'b0);

        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d unchecked entries, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
